clk_div_sel_ctrl: RTL
=====================

# clk_div_sel_ctrl

Run-time controller for the binary clock-divider datapath. It owns a 5-bit free-running divide counter and selects one power-of-two ratio (/2 to /32) to drive a single divided-clock output. Ratio changes arrive over a valid/ready handshake and are applied only at the common all-zero counter boundary, so the output never glitches or emits a runt phase. It sits between the configuration register block and downstream consumers of the divided clock and its tick.

## Interface
- SEL_W, 3: width of the ratio select; ratio = 2^(sel+1).
- CNT_W, 5: divide counter width; must equal SEL_MAX+1.
- clk  in  1  master clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = counter advances, 0 = counter cleared and held.
- cfg_valid  in  1  ratio-change request.
- cfg_sel  in  SEL_W  requested select; valid values 0..4 (/2,/4,/8,/16,/32).
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
- clk_out  out  1  registered divided clock, equal to count[cur_sel].
- tick  out  1  registered one-cycle pulse in the first cycle clk_out is high.
- cur_sel  out  SEL_W  active select.
- busy  out  1  accepted change pending, i.e. state PEND.
- cfg_err  out  1  one-cycle pulse when an out-of-range select is accepted.

## Operation
- States: IDLE (run=0), RUN (run=1, no pending change), PEND (run=1, pend_sel held).
- cfg_ready = 1 in IDLE and RUN, 0 in PEND. Combinational from state only.
- Accepted cfg_sel > 4: no state change and no pend_sel load; cfg_err = 1 the next cycle.
- IDLE with a valid accept: cur_sel <= cfg_sel the next cycle. Counter stays 0.
- RUN with a valid accept: pend_sel <= cfg_sel, go to PEND.
- PEND and count == 31 with run = 1: cur_sel <= pend_sel, count <= 0, go to RUN. All bits of count are 0 after the wrap, so clk_out is 0 under both the old and new select.
- run 1->0 in any state: count <= 0, go to IDLE. A PEND value is applied immediately (cur_sel <= pend_sel).
- IDLE with run = 1: go to RUN, count starts incrementing.
- count wraps 31 -> 0 modulo 2^CNT_W and never saturates.
- clk_out and tick are flops computed from next-state count/cur_sel. tick_next = run && next_count[cur_sel_next:0] == 2^cur_sel_next.

## Timing
- Reset values: count 0, cur_sel 0, pend_sel 0, state IDLE, clk_out 0, tick 0, cfg_err 0, busy 0. cfg_ready = 1.
- clk_out period = 2^(cur_sel+1) clk cycles with 50 % duty. First rising edge is 2^cur_sel cycles after run rises.
- Change latency in RUN: applied on the clk edge where count goes 31->0. Worst case is 32 cycles after accept, best case 1 cycle.
- An accept in the same cycle as count == 31 still goes to PEND. It is applied at the next boundary, 32 cycles later.
- An accept in IDLE takes effect on the next edge.
- cfg_err, busy and cur_sel update one cycle after the accept edge.
- Async rst mid-PEND discards pend_sel. Outputs reach reset values immediately, with no clock required.

## Structure
- Package clk_div_pkg holds:
  - SEL_MAX = 4 and CNT_W = 5
  - typedef enum logic [1:0] {IDLE, RUN, PEND} state_t
  - function sel_valid(sel)
- Sub-module clk_div_counter (CNT_W-bit up-counter with enable and synchronous clear) holds the counter. The controller instantiates it and contains the FSM, select registers and output flops.

## Test plan
- Reset, then run=1 with cur_sel 0 -> clk_out toggles every cycle and tick pulses every 2 cycles. Assert rst mid-run -> all outputs 0 asynchronously and cfg_ready = 1.
- IDLE, cfg_sel = 3 accepted, then run=1 -> cur_sel = 3 after 1 cycle. clk_out goes high 8 cycles after run and has a 16-cycle period.
- RUN at /4, accept cfg_sel = 4 at count = 5 -> busy = 1 for 26 cycles and cfg_ready = 0. Switch occurs at the 31->0 wrap, then clk_out is /32 with no pulse shorter than 2 cycles.
- Accept in the cycle with count = 31 -> change applied 32 cycles later, not at the current wrap.
- Accept cfg_sel = 6 in RUN -> cfg_err pulses for 1 cycle, cur_sel unchanged and busy stays 0.
- In PEND (pend_sel = 2), drop run -> IDLE next cycle, cur_sel = 2, count = 0, clk_out = 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and limits for the power-of-two clock divider controller.
package clk_div_pkg;

    localparam int unsigned SEL_MAX = 4;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    function automatic logic sel_valid(input int unsigned sel);
        return sel <= SEL_MAX;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Free-running divide counter with enable and synchronous clear.
// The next-state value is exported so the controller can register outputs from it.
module clk_div_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/clk_div_sel_ctrl.sv
// Run-time ratio select for the power-of-two clock divider.
// Ratio changes are deferred to the all-zero counter boundary so clk_out never emits a runt phase.
module clk_div_sel_ctrl #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             cfg_err
);
    import clk_div_pkg::state_t;
    import clk_div_pkg::IDLE;
    import clk_div_pkg::RUN;
    import clk_div_pkg::PEND;
    import clk_div_pkg::sel_valid;

    state_t             state;
    state_t             state_next;
    logic [SEL_W-1:0]   pend_sel;
    logic [SEL_W-1:0]   pend_sel_next;
    logic [SEL_W-1:0]   cur_sel_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   phase_mask;
    logic               accept;
    logic               sel_ok;
    logic               cfg_err_next;
    logic               clk_out_next;
    logic               tick_next;

    clk_div_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (run),
        .clr        (!run),
        .count      (count),
        .count_next (count_next)
    );

    assign cfg_ready = (state != PEND);
    assign busy      = (state == PEND);

    always_comb begin
        accept        = cfg_valid && cfg_ready;
        sel_ok        = sel_valid(32'(cfg_sel));
        cfg_err_next  = accept && !sel_ok;
        state_next    = state;
        cur_sel_next  = cur_sel;
        pend_sel_next = pend_sel;

        if (!run) begin
            // Stopping clears the counter, so any select can be applied at once.
            state_next = IDLE;
            if (state == PEND) begin
                cur_sel_next = pend_sel;
            end else if (accept && sel_ok) begin
                cur_sel_next = cfg_sel;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_next = RUN;
                    if (accept && sel_ok) begin
                        cur_sel_next = cfg_sel;
                    end
                end
                RUN: begin
                    if (accept && sel_ok) begin
                        pend_sel_next = cfg_sel;
                        state_next    = PEND;
                    end
                end
                PEND: begin
                    if (count == '1) begin
                        cur_sel_next = pend_sel;
                        state_next   = RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        phase_mask = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            phase_mask[i] = (i <= 32'(cur_sel_next));
        end
        clk_out_next = count_next[cur_sel_next];
        tick_next    = run && ((count_next & phase_mask) == (CNT_W'(1) << cur_sel_next));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel  <= '0;
            pend_sel <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cur_sel  <= cur_sel_next;
            pend_sel <= pend_sel_next;
            clk_out  <= clk_out_next;
            tick     <= tick_next;
            cfg_err  <= cfg_err_next;
        end
    end

endmodule
